prm_sweep_sched: RTL and testbench

- Sequences the edge-mask LUT checker bank over the full x/y/z coordinate space.
- Issues one coordinate per cycle together with a latched part select and bit index.
- Collects the checker's hit response after a fixed latency and counts hits into result_imp.
- Sits between the top-level control inputs and the chk512p0..p7 bank; it replaces free-running input muxing with a start/busy/done-controlled sweep.

---
 rtl/prm_sweep_sched_if.sv | 38 +++
 rtl/prm_sweep_sched.sv | 147 ++++++++++++++
 tb/tb_prm_sweep_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/prm_sweep_sched_if.sv
// Control/checker-bank bundle for prm_sweep_sched. The scheduler uses slave and the driver uses master.
// The first-hit outputs exist only when PRM_SWEEP_FIRST_HIT_EN is defined.
interface prm_sweep_sched_if #(
  parameter int XW = 4,
  parameter int YW = 5,
  parameter int ZW = 5
);
  logic          start;
  logic          abort;
  logic [2:0]    sel1;
  logic [8:0]    bit_idx;
  logic          chk_hit;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ZW-1:0] z;
  logic [2:0]    chk_part;
  logic [8:0]    chk_bit;
  logic          chk_valid;
  logic          busy;
  logic          done;
  logic [31:0]   result_imp;
`ifdef PRM_SWEEP_FIRST_HIT_EN
  logic                  first_hit_vld;
  logic [XW+YW+ZW-1:0]   first_hit_xyz;

  modport master (output start, abort, sel1, bit_idx, chk_hit,
                  input  x, y, z, chk_part, chk_bit, chk_valid, busy, done, result_imp,
                         first_hit_vld, first_hit_xyz);
  modport slave  (input  start, abort, sel1, bit_idx, chk_hit,
                  output x, y, z, chk_part, chk_bit, chk_valid, busy, done, result_imp,
                         first_hit_vld, first_hit_xyz);
`else
  modport master (output start, abort, sel1, bit_idx, chk_hit,
                  input  x, y, z, chk_part, chk_bit, chk_valid, busy, done, result_imp);
  modport slave  (input  start, abort, sel1, bit_idx, chk_hit,
                  output x, y, z, chk_part, chk_bit, chk_valid, busy, done, result_imp);
`endif
endinterface

// File: rtl/prm_sweep_sched.sv
// prm_sweep_sched: start/busy/done sweep of x/y/z over the checker bank, counting hits in result_imp.
// Optional PRM_SWEEP_FIRST_HIT_EN records the coordinate of the first counted hit.
module prm_sweep_sched #(
  parameter int XW  = 4,
  parameter int YW  = 5,
  parameter int ZW  = 5,
  parameter int LAT = 2
) (
  input logic              CLK,
  input logic              RST,
  prm_sweep_sched_if.slave bus
);
  localparam int CW = XW + YW + ZW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  xyz_q, xyz_d;
  logic [2:0]     part_q, part_d;
  logic [8:0]     bit_q, bit_d;
  logic           vld_q, vld_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [LAT-1:0] vld_pipe_q, vld_pipe_d, pipe_shift;
  logic [31:0]    res_q, res_d;
  logic           tail_hit, accept;

  assign accept   = (state_q == IDLE) && bus.start && !bus.abort;
  assign tail_hit = vld_pipe_q[LAT-1] & bus.chk_hit;

  always_comb begin
    pipe_shift = (vld_pipe_q << 1) | LAT'(vld_q);
    state_d    = state_q;
    xyz_d      = xyz_q;
    part_d     = part_q;
    bit_d      = bit_q;
    vld_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    vld_pipe_d = pipe_shift;
    res_d      = (tail_hit && res_q != '1) ? res_q + 32'd1 : res_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        xyz_d   = '0;
        part_d  = bus.sel1;
        bit_d   = bus.bit_idx;
        res_d   = '0;
        vld_d   = 1'b1;
        busy_d  = 1'b1;
      end
      RUN: if (bus.abort) begin
        state_d    = IDLE;
        vld_pipe_d = '0;
      end else if (xyz_q == '1) begin
        state_d = DRAIN;
        busy_d  = 1'b1;
      end else begin
        xyz_d  = xyz_q + CW'(1);
        vld_d  = 1'b1;
        busy_d = 1'b1;
      end
      // Leave DRAIN once the shifted pipeline would hold no live issue.
      DRAIN: if (bus.abort) begin
        state_d    = IDLE;
        vld_pipe_d = '0;
      end else if (pipe_shift == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      xyz_q      <= '0;
      part_q     <= '0;
      bit_q      <= '0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      xyz_q      <= xyz_d;
      part_q     <= part_d;
      bit_q      <= bit_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
      res_q      <= res_d;
    end
  end

  assign bus.x          = xyz_q[CW-1 -: XW];
  assign bus.y          = xyz_q[ZW +: YW];
  assign bus.z          = xyz_q[ZW-1:0];
  assign bus.chk_part   = part_q;
  assign bus.chk_bit    = bit_q;
  assign bus.chk_valid  = vld_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result_imp = res_q;

`ifdef PRM_SWEEP_FIRST_HIT_EN
  logic [LAT-1:0][CW-1:0] xyz_pipe_q, xyz_pipe_d;
  logic                   fh_vld_q, fh_vld_d;
  logic [CW-1:0]          fh_xyz_q, fh_xyz_d;

  // Coordinates ride alongside the valid bits so the tail names the issuing cycle.
  always_comb begin
    xyz_pipe_d[0] = xyz_q;
    for (int i = 1; i < LAT; i++) xyz_pipe_d[i] = xyz_pipe_q[i-1];
    fh_vld_d = fh_vld_q;
    fh_xyz_d = fh_xyz_q;
    if (accept) begin
      fh_vld_d = 1'b0;
      fh_xyz_d = '0;
    end else if (tail_hit && !fh_vld_q) begin
      fh_vld_d = 1'b1;
      fh_xyz_d = xyz_pipe_q[LAT-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      xyz_pipe_q <= '0;
      fh_vld_q   <= 1'b0;
      fh_xyz_q   <= '0;
    end else begin
      xyz_pipe_q <= xyz_pipe_d;
      fh_vld_q   <= fh_vld_d;
      fh_xyz_q   <= fh_xyz_d;
    end
  end

  assign bus.first_hit_vld = fh_vld_q;
  assign bus.first_hit_xyz = fh_xyz_q;
`endif
endmodule

// File: tb/tb_prm_sweep_sched.sv
// Bench for prm_sweep_sched: a hit-table checker responder plus directed/random sweeps
// with expected coordinates and counts derived arithmetically from the issue index.
module tb_prm_sweep_sched;
  localparam int XW  = 4;
  localparam int YW  = 5;
  localparam int ZW  = 5;
  localparam int LAT = 2;
  localparam int CW  = XW + YW + ZW;
  localparam int N   = 1 << CW;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  prm_sweep_sched_if #(.XW(XW), .YW(YW), .ZW(ZW)) bus();
  prm_sweep_sched #(.XW(XW), .YW(YW), .ZW(ZW), .LAT(LAT)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  bit hit_tab [N];
  bit resp_q [$];

  // Checker bank model: answers for the coordinate seen LAT cycles earlier.
  always @(negedge CLK) begin
    resp_q.push_back(bus.chk_valid && hit_tab[{bus.x, bus.y, bus.z}]);
    if (resp_q.size() > LAT) bus.chk_hit = resp_q.pop_front();
    else bus.chk_hit = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, bus.x, 0);
    check({tag, "_y"}, bus.y, 0);
    check({tag, "_z"}, bus.z, 0);
    check({tag, "_part"}, bus.chk_part, 0);
    check({tag, "_bit"}, bus.chk_bit, 0);
    check({tag, "_valid"}, bus.chk_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_result"}, bus.result_imp, 0);
`ifdef PRM_SWEEP_FIRST_HIT_EN
    check({tag, "_fh_vld"}, bus.first_hit_vld, 0);
    check({tag, "_fh_xyz"}, bus.first_hit_xyz, 0);
`endif
  endtask

  // mode 0: every coordinate hits; 1: only (3,7,1) hits; 2: random table.
  task automatic sweep(input int mode, input int abort_at, input int rst_at, input bit pokes,
                       input logic [2:0] s, input logic [8:0] b);
    int exp_cnt = 0;
    int first = -1;
    int k, kk;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       hit_tab[i] = 1'b1;
        1:       hit_tab[i] = (i == ((3 << (YW + ZW)) | (7 << ZW) | 1));
        default: hit_tab[i] = ($urandom_range(0, 3) == 0);
      endcase
    end
    @(negedge CLK);
    bus.sel1 = s; bus.bit_idx = b; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    for (int c = 1; c <= N + LAT + 1; c++) begin
      k = c - 1 - LAT;
      if (k >= 1 && k <= N && hit_tab[k-1]) begin
        exp_cnt++;
        if (first < 0) first = k - 1;
      end
      kk = (c <= N) ? c - 1 : N - 1;
      check("chk_valid", bus.chk_valid, c <= N);
      check("x", bus.x, kk / (1 << (YW + ZW)));
      check("y", bus.y, (kk / (1 << ZW)) % (1 << YW));
      check("z", bus.z, kk % (1 << ZW));
      check("busy", bus.busy, c <= N + LAT);
      check("done", bus.done, c == N + LAT + 1);
      check("chk_part", bus.chk_part, s);
      check("chk_bit", bus.chk_bit, b);
      check("result_imp", bus.result_imp, exp_cnt);
      if (c == abort_at) bus.abort = 1'b1;
      if (c == rst_at) RST = 1'b1;
      if (pokes && (c == 50 || c == N + LAT + 1)) begin
        bus.start = 1'b1; bus.sel1 = 3'd2; bus.bit_idx = 9'h000;
      end
      @(negedge CLK);
      bus.abort = 1'b0; RST = 1'b0; bus.start = 1'b0;
      if (c == abort_at) begin
        k = c - LAT;
        if (k >= 1 && hit_tab[k-1]) exp_cnt++;
        if (mode == 0) check("abort_count", bus.result_imp, abort_at - LAT);
        for (int j = 0; j < LAT + 3; j++) begin
          check("abort_busy", bus.busy, 0);
          check("abort_valid", bus.chk_valid, 0);
          check("abort_done", bus.done, 0);
          check("abort_result", bus.result_imp, exp_cnt);
          @(negedge CLK);
        end
        return;
      end
      if (c == rst_at) begin
        check_zero("rst_mid");
        return;
      end
    end
    check("post_busy", bus.busy, 0);
    check("post_valid", bus.chk_valid, 0);
    check("post_done", bus.done, 0);
    check("post_result", bus.result_imp, exp_cnt);
    if (mode == 0) check("full_count", bus.result_imp, 32'h0000_4000);
    if (mode == 1) check("single_count", bus.result_imp, 1);
`ifdef PRM_SWEEP_FIRST_HIT_EN
    check("fh_vld", bus.first_hit_vld, first >= 0);
    check("fh_xyz", bus.first_hit_xyz, (first >= 0) ? first : 0);
    if (mode == 1) check("fh_xyz_const", bus.first_hit_xyz, 14'h0CE1);
`endif
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.sel1 = '0; bus.bit_idx = '0;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RST = 1'b0;

    // start and abort together in IDLE: abort wins
    bus.start = 1'b1; bus.abort = 1'b1; bus.sel1 = 3'd6; bus.bit_idx = 9'h155;
    @(negedge CLK);
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) begin
      check("idle_sa_busy", bus.busy, 0);
      check("idle_sa_valid", bus.chk_valid, 0);
      check("idle_sa_part", bus.chk_part, 0);
      @(negedge CLK);
    end

    sweep(0, -1, -1, 1'b0, 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)));
    sweep(1, -1, -1, 1'b1, 3'd5, 9'h1A3);
    sweep(0, 100, -1, 1'b0, 3'd1, 9'h0FF);
    sweep(2, $urandom_range(200, 3000), -1, 1'b0, 3'd3, 9'h042);
    sweep(2, -1, 500, 1'b0, 3'd7, 9'h1FF);
    sweep(0, -1, -1, 1'b0, 3'd4, 9'h080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
